// File: rtl/imem_loader_pkg.sv
// Shared instruction-memory map constants and loader FSM encoding.
package imem_loader_pkg;
  localparam int          IMEM_ADDR_W    = 6;
  localparam int          IMEM_DEPTH     = 64;
  localparam logic [31:0] IMEM_FILL_WORD = 32'hFFFF_FFFF;
  localparam int          IMEM_TIMEOUT   = 1024;

  typedef enum logic [2:0] {IDLE, RECV, WRITE, FILL, FIN} ld_state_e;
endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream source, instruction-memory write port and CPU control of the loader.
interface imem_loader_if import imem_loader_pkg::*; #(
  parameter int ADDR_W = IMEM_ADDR_W
);
  logic              Start;
  logic [ADDR_W:0]   Word_Count;
  logic              Byte_Valid;
  logic [7:0]        Byte_Data;
  logic              Byte_Ready;
  logic              Mem_We;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [31:0]       Mem_Wdata;
  logic              Cpu_Hold;
  logic              Done;
  logic              Err;

  modport master (
    output Start, Word_Count, Byte_Valid, Byte_Data,
    input  Byte_Ready, Mem_We, Mem_Addr, Mem_Wdata, Cpu_Hold, Done, Err
  );
  modport slave (
    input  Start, Word_Count, Byte_Valid, Byte_Data,
    output Byte_Ready, Mem_We, Mem_Addr, Mem_Wdata, Cpu_Hold, Done, Err
  );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs four big-endian bytes into a word; word/word_valid present the full
// word combinationally in the cycle the fourth byte is accepted.
module word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        accept,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [1:0]  idx;
  logic [23:0] sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      sh  <= '0;
    end else if (clr) begin
      idx <= '0;
      sh  <= '0;
    end else if (accept) begin
      idx <= idx + 2'd1;
      sh  <= {sh[15:0], data};
    end
  end

  assign word       = {sh, data};
  assign word_valid = accept && (idx == 2'd3);
endmodule

// File: rtl/imem_loader.sv
// Loads a byte-streamed program into instruction memory, pads the remainder
// with FILL_WORD and holds the CPU until the load completes.
module imem_loader import imem_loader_pkg::*; #(
  parameter int          ADDR_W    = IMEM_ADDR_W,
  parameter int          DEPTH     = IMEM_DEPTH,
  parameter logic [31:0] FILL_WORD = IMEM_FILL_WORD,
  parameter int          TIMEOUT   = IMEM_TIMEOUT
)(
  input  logic         Clk,
  input  logic         Rst,
  imem_loader_if.slave bus
);
  localparam int CNT_W = ADDR_W + 1;

  ld_state_e         state, state_nx;
  logic [CNT_W-1:0]  n, n_nx, addr, addr_nx, wc_clamp;
  logic [15:0]       tmo, tmo_nx;
  logic              start_acc, tmo_hit, accept, word_valid;
  logic [31:0]       word;
  logic              we_d, done_d, hold_d, err_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d;

  assign bus.Byte_Ready = (state == RECV);
  assign accept         = bus.Byte_Valid && bus.Byte_Ready;
  assign wc_clamp       = (bus.Word_Count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : bus.Word_Count;

  word_assembler u_asm (
    .clk       (Clk),
    .rst_n     (Rst),
    .clr       (start_acc),
    .accept    (accept),
    .data      (bus.Byte_Data),
    .word      (word),
    .word_valid(word_valid)
  );

  // Outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state         <= IDLE;
      n             <= '0;
      addr          <= '0;
      tmo           <= '0;
      bus.Mem_We    <= 1'b0;
      bus.Mem_Addr  <= '0;
      bus.Mem_Wdata <= '0;
      bus.Cpu_Hold  <= 1'b0;
      bus.Done      <= 1'b0;
      bus.Err       <= 1'b0;
    end else begin
      state         <= state_nx;
      n             <= n_nx;
      addr          <= addr_nx;
      tmo           <= tmo_nx;
      bus.Mem_We    <= we_d;
      bus.Mem_Addr  <= addr_d;
      bus.Mem_Wdata <= wdata_d;
      bus.Cpu_Hold  <= hold_d;
      bus.Done      <= done_d;
      bus.Err       <= err_d;
    end
  end

  always_comb begin
    state_nx  = state;
    n_nx      = n;
    addr_nx   = addr;
    tmo_nx    = tmo;
    start_acc = 1'b0;
    tmo_hit   = 1'b0;
    case (state)
      IDLE: if (bus.Start) begin
        start_acc = 1'b1;
        n_nx      = wc_clamp;
        addr_nx   = '0;
        tmo_nx    = '0;
        state_nx  = (wc_clamp == '0) ? FILL : RECV;
      end
      RECV: if (accept) begin
        tmo_nx = '0;
        if (word_valid) state_nx = WRITE;
      end else if (tmo == 16'(TIMEOUT - 1)) begin
        tmo_hit  = 1'b1;
        state_nx = IDLE;
      end else begin
        tmo_nx = tmo + 16'd1;
      end
      WRITE: begin
        addr_nx = addr + 1'b1;
        if (addr_nx == n) state_nx = (n < CNT_W'(DEPTH)) ? FILL : FIN;
        else              state_nx = RECV;
      end
      FILL: begin
        addr_nx = addr + 1'b1;
        if (addr == CNT_W'(DEPTH - 1)) state_nx = FIN;
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    we_d    = (state_nx == WRITE) || (state_nx == FILL);
    addr_d  = we_d ? addr_nx[ADDR_W-1:0] : '0;
    wdata_d = (state_nx == WRITE) ? word :
              (state_nx == FILL)  ? FILL_WORD : 32'h0;
    done_d  = (state_nx == FIN);
    hold_d  = bus.Cpu_Hold;
    err_d   = bus.Err;
    if (start_acc) begin
      hold_d = 1'b1;
      err_d  = 1'b0;
    end else begin
      if (state_nx == FIN) hold_d = 1'b0;
      if (tmo_hit)         err_d  = 1'b1;
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: write log captured on the falling edge.
module tb_imem_loader;
  localparam int AW  = 6;
  localparam int D   = 64;
  localparam int TMO = 1024;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(AW)) bus();
  imem_loader #(.ADDR_W(AW), .DEPTH(D), .FILL_WORD(32'hFFFF_FFFF), .TIMEOUT(TMO)) dut (
    .Clk(clk), .Rst(rst_n), .bus(bus)
  );

  int checks = 0, errors = 0, cyc = 0;
  int          wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];
  int   done_n = 0, done_cyc = 0, rdy_cnt = 0;
  logic done_hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.Mem_We) begin
      wr_addr.push_back(int'(bus.Mem_Addr));
      wr_data.push_back(bus.Mem_Wdata);
      wr_cyc.push_back(cyc);
    end
    if (bus.Done) begin
      done_n    = done_n + 1;
      done_cyc  = cyc;
      done_hold = bus.Cpu_Hold;
    end
    if (bus.Byte_Ready) rdy_cnt = rdy_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_load(input logic [AW:0] wc);
    bus.Start      = 1'b1;
    bus.Word_Count = wc;
    tick;
    bus.Start = 1'b0;
  endtask

  // acc returns the cycle in which the byte sat on the bus with Ready high.
  task automatic send_byte(input logic [7:0] b, input int gap, output int acc);
    int k = 0;
    bus.Byte_Valid = 1'b0;
    repeat (gap) tick;
    bus.Byte_Valid = 1'b1;
    bus.Byte_Data  = b;
    while (!bus.Byte_Ready && k < 50) begin tick; k++; end
    if (!bus.Byte_Ready) chk("rdy_to", 32'(bus.Byte_Ready), 32'd1);
    acc = cyc;
    tick;
    bus.Byte_Valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, output int acc);
    logic [31:0] t;
    t = w;
    for (int b = 0; b < 4; b++) send_byte(t[31-8*b -: 8], gap, acc);
  endtask

  task automatic wait_done(input int d0);
    int k = 0;
    while (done_n == d0 && k < 400) begin tick; k++; end
    if (done_n == d0) chk("done_to", 32'(done_n - d0), 32'd1);
  endtask

  // Entries base..base+cnt-1 must be fill writes at a0.. on consecutive cycles.
  task automatic chk_fill(input string tag, input int base, input int a0, input int cnt);
    int bad = 0;
    for (int i = 0; i < cnt; i++) begin
      if (base + i >= wr_addr.size()) bad++;
      else if (wr_addr[base+i] != a0 + i || wr_data[base+i] != 32'hFFFF_FFFF) bad++;
      else if (i > 0 && wr_cyc[base+i] != wr_cyc[base+i-1] + 1) bad++;
    end
    chk(tag, 32'(bad), 32'd0);
  endtask

  function automatic logic [31:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i);
    return {b, b ^ 8'hA5, 8'h5A, ~b};
  endfunction

  initial begin
    int base, d0, r0, acc, acc4, bad;
    bus.Start = 1'b0; bus.Word_Count = '0; bus.Byte_Valid = 1'b0; bus.Byte_Data = '0;

    // reset state
    #2;
    chk("rst_rdy",   32'(bus.Byte_Ready), 32'd0);
    chk("rst_we",    32'(bus.Mem_We),     32'd0);
    chk("rst_addr",  32'(bus.Mem_Addr),   32'd0);
    chk("rst_wdata", bus.Mem_Wdata,       32'd0);
    chk("rst_hold",  32'(bus.Cpu_Hold),   32'd0);
    chk("rst_done",  32'(bus.Done),       32'd0);
    chk("rst_err",   32'(bus.Err),        32'd0);
    #10 rst_n = 1'b1;
    tick;

    // basic load, two words back-to-back
    base = wr_addr.size(); d0 = done_n;
    start_load(7'd2);
    chk("b_hold", 32'(bus.Cpu_Hold), 32'd1);
    chk("b_rdy",  32'(bus.Byte_Ready), 32'd1);
    send_word(32'h2002_0005, 0, acc4);
    send_word(32'h2003_000C, 0, acc);
    wait_done(d0);
    chk("b_nwr",  32'(wr_addr.size() - base), 32'd64);
    chk("b_a0",   32'(wr_addr[base]),   32'd0);
    chk("b_d0",   wr_data[base],        32'h2002_0005);
    chk("b_lat0", 32'(wr_cyc[base] - acc4), 32'd1);
    chk("b_a1",   32'(wr_addr[base+1]), 32'd1);
    chk("b_d1",   wr_data[base+1],      32'h2003_000C);
    chk_fill("b_fill", base + 2, 2, 62);
    chk("b_done", 32'(done_n - d0), 32'd1);
    chk("b_dcyc", 32'(done_cyc - wr_cyc[base+63]), 32'd1);
    chk("b_dhold", 32'(done_hold), 32'd0);
    chk("b_err",  32'(bus.Err), 32'd0);

    // stalled source, 3-cycle gaps
    base = wr_addr.size(); d0 = done_n;
    start_load(7'd1);
    send_word(32'h00E2_2025, 3, acc);
    wait_done(d0);
    chk("s_nwr", 32'(wr_addr.size() - base), 32'd64);
    chk("s_a0",  32'(wr_addr[base]), 32'd0);
    chk("s_d0",  wr_data[base], 32'h00E2_2025);
    chk("s_lat", 32'(wr_cyc[base] - acc), 32'd1);
    chk_fill("s_fill", base + 1, 1, 63);
    chk("s_err", 32'(bus.Err), 32'd0);

    // zero word count: pure fill, never ready
    base = wr_addr.size(); d0 = done_n; r0 = rdy_cnt;
    start_load(7'd0);
    wait_done(d0);
    chk("z_rdy", 32'(rdy_cnt - r0), 32'd0);
    chk("z_nwr", 32'(wr_addr.size() - base), 32'd64);
    chk_fill("z_fill", base, 0, 64);
    chk("z_dcyc", 32'(done_cyc - wr_cyc[base+63]), 32'd1);

    // over-count: clamps to 64 words, no fill
    base = wr_addr.size(); d0 = done_n;
    start_load(7'd100);
    for (int w = 0; w < D; w++) send_word(pat(w), 0, acc);
    wait_done(d0);
    chk("o_nwr", 32'(wr_addr.size() - base), 32'd64);
    bad = 0;
    for (int w = 0; w < D; w++)
      if (base + w >= wr_addr.size() || wr_addr[base+w] != w || wr_data[base+w] != pat(w)) bad++;
    chk("o_data", 32'(bad), 32'd0);
    chk("o_dcyc", 32'(done_cyc - wr_cyc[base+63]), 32'd1);
    chk("o_lat",  32'(wr_cyc[base+63] - acc), 32'd1);
    r0 = rdy_cnt;
    bus.Byte_Valid = 1'b1; bus.Byte_Data = 8'h77;
    repeat (5) tick;
    bus.Byte_Valid = 1'b0;
    chk("o_xs", 32'(rdy_cnt - r0), 32'd0);

    // timeout after 5 of 12 bytes
    base = wr_addr.size(); d0 = done_n;
    start_load(7'd3);
    send_word(32'h1122_3344, 0, acc);
    send_byte(8'h55, 0, acc);
    begin
      int k = 0;
      while (!bus.Err && k < 2000) begin tick; k++; end
    end
    chk("t_cyc",  32'(cyc - acc), 32'(TMO + 1));
    chk("t_err",  32'(bus.Err), 32'd1);
    chk("t_nwr",  32'(wr_addr.size() - base), 32'd1);
    chk("t_d0",   wr_data[base], 32'h1122_3344);
    chk("t_hold", 32'(bus.Cpu_Hold), 32'd1);
    chk("t_rdy",  32'(bus.Byte_Ready), 32'd0);
    chk("t_done", 32'(done_n - d0), 32'd0);
    start_load(7'd0);
    chk("t_clr",  32'(bus.Err), 32'd0);
    chk("t_hold2", 32'(bus.Cpu_Hold), 32'd1);
    wait_done(d0);

    // start pulsed during fill is ignored
    base = wr_addr.size(); d0 = done_n;
    start_load(7'd0);
    repeat (10) tick;
    start_load(7'd5);
    wait_done(d0);
    chk("f_nwr", 32'(wr_addr.size() - base), 32'd64);
    chk_fill("f_fill", base, 0, 64);
    chk("f_done", 32'(done_n - d0), 32'd1);

    // async reset mid-RECV
    start_load(7'd2);
    send_byte(8'hAB, 0, acc);
    send_byte(8'hCD, 0, acc);
    bus.Byte_Valid = 1'b1; bus.Byte_Data = 8'h99;
    #2 rst_n = 1'b0;
    #1;
    chk("r_rdy",  32'(bus.Byte_Ready), 32'd0);
    chk("r_hold", 32'(bus.Cpu_Hold),   32'd0);
    chk("r_we",   32'(bus.Mem_We),     32'd0);
    #1 rst_n = 1'b1;
    base = wr_addr.size(); d0 = done_n;
    tick;
    chk("r_idle", 32'(bus.Byte_Ready), 32'd0);
    bus.Byte_Valid = 1'b0;
    start_load(7'd1);
    send_word(32'hDEAD_BEEF, 0, acc);
    wait_done(d0);
    chk("r_a0", 32'(wr_addr[base]), 32'd0);
    chk("r_d0", wr_data[base], 32'hDEAD_BEEF);
    chk("r_nwr", 32'(wr_addr.size() - base), 32'd64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory: the MIPS core only reads program words, and this block loads them.
- Receives a big-endian byte stream over a valid/ready handshake and assembles 32-bit instruction words.
- Writes the words sequentially into instruction memory from address 0, then pads the rest of memory with a fill word.
- Holds the CPU (Cpu_Hold) for the whole load and releases it with a Done pulse, so new programs load without re-synthesis.

Parameters:
- ADDR_W, 6, instruction-memory address width in words.
- DEPTH, 64, number of memory words; must be ≤ 2^ADDR_W.
- FILL_WORD, 32'hFFFFFFFF, value written to every address beyond the loaded program.
- TIMEOUT, 1024, maximum idle cycles between bytes while receiving; 16-bit counter.

Ports:
- Clk  in  1  system clock; all logic on the rising edge.
- Rst  in  1  asynchronous, active-low reset (asserted at 0).
- Start  in  1  single-cycle load request; ignored unless the FSM is in IDLE.
- Word_Count  in  ADDR_W+1  number of program words; sampled on an accepted Start.
- Byte_Valid  in  1  source has a byte on Byte_Data.
- Byte_Data  in  8  stream byte; most-significant byte of each word first.
- Byte_Ready  out  1  loader can accept a byte this cycle.
- Mem_We  out  1  instruction-memory write enable.
- Mem_Addr  out  ADDR_W  word address.
- Mem_Wdata  out  32  write data.
- Cpu_Hold  out  1  holds the CPU in reset while high.
- Done  out  1  one-cycle pulse when the load completes.
- Err  out  1  sticky timeout flag.

Behaviour:
- Reset (Rst=0, async): state IDLE.
  - Outputs: Byte_Ready=0, Mem_We=0, Mem_Addr=0, Mem_Wdata=0, Cpu_Hold=0, Done=0, Err=0.
  - Internal state cleared: byte index, address counter, timeout counter.
- All outputs are registered except Byte_Ready, which is decoded from the state (high exactly in RECV).
- IDLE: on Start=1:
  - Latch min(Word_Count, DEPTH) as the target count N.
  - Clear the address counter and Err; set Cpu_Hold=1.
  - Go to RECV if N>0, otherwise to FILL.
- RECV: a byte is accepted when Byte_Valid && Byte_Ready.
  - Byte index 0..3 places the byte at bits [31:24], [23:16], [15:8], [7:0] respectively.
  - On the 4th accept, go to WRITE; the timeout counter clears on every accept.
- WRITE: exactly one cycle, with Byte_Ready=0, Mem_We=1, Mem_Addr = address counter, Mem_Wdata = assembled word.
  - Write latency: Mem_We rises the cycle after the 4th byte is accepted.
  - Then increment the address counter.
  - If the counter equals N: go to FILL when N<DEPTH, otherwise to FIN.
  - Else return to RECV with byte index 0.
- FILL: one write per cycle (Mem_We=1, Mem_Wdata=FILL_WORD) at addresses N..DEPTH-1.
  - After the write to DEPTH-1, go to FIN.
- FIN: one cycle with Done=1 and Cpu_Hold=0, then go to IDLE.
- Mem_We is 0 in every state except WRITE and FILL.
- Timeout: in RECV, the timeout counter increments every cycle without an accepted byte.
  - On reaching TIMEOUT: Err=1, go to IDLE. Cpu_Hold stays 1 (the CPU never runs a partial program) and Done is not pulsed.
  - Err and Cpu_Hold clear only on the next accepted Start or on reset.
- Start outside IDLE is ignored, with no effect on any counter.
- Byte_Valid outside RECV is ignored; those bytes are not consumed.
- Word_Count > DEPTH is clamped to DEPTH; excess bytes are never accepted.
- Reset mid-load aborts immediately: all outputs go to their reset values and memory keeps whatever was already written.

Decomposition:
- Shared package holds the following, reused by the top-level and any other memory-map users:
  - FSM state encoding: IDLE, RECV, WRITE, FILL, FIN.
  - Default FILL_WORD constant.
  - Instruction-memory DEPTH/ADDR_W constants.
- One natural sub-module, word_assembler: byte-index counter plus 32-bit shift register, with a word_valid strobe and a clear.
- The loader FSM, address counter and timeout counter stay in imem_loader.

Test Plan:
- Basic load: Word_Count=2; bytes 20 02 00 05 20 03 00 0C back-to-back.
  - Required: Mem_We at addr 0 data 20020005, then addr 1 data 2003000C.
  - Then addrs 2..63 written FFFFFFFF, one per cycle.
  - Then a Done pulse, and Cpu_Hold falls in the same cycle.
- Stalled source: Word_Count=1; bytes 00 E2 20 25 with 3-cycle Byte_Valid gaps.
  - Required: a single write of 00E22025 to addr 0, one cycle after the last accept.
  - No Err, because the gaps are below TIMEOUT.
- Zero and over-count:
  - Word_Count=0: Byte_Ready never rises; addrs 0..63 get FFFFFFFF; Done after 64 writes.
  - Word_Count=100: exactly 64 words are accepted, FILL is skipped, and Done follows the write to addr 63.
- Timeout: Word_Count=3 and only 5 bytes are sent.
  - Required: exactly 1 write; TIMEOUT cycles after the 5th byte, Err=1 and the FSM returns to IDLE.
  - Cpu_Hold stays 1 and Done is never pulsed; a new Start clears Err.
- Start while busy, and reset mid-load:
  - Start pulsed during FILL: ignored, with fill addresses unchanged.
  - Rst=0 asynchronously mid-RECV: Mem_We, Cpu_Hold and Byte_Ready drop to 0 before the next clock edge, and the FSM is in IDLE after release.
